// File: rtl/bram_frame_reader_if.sv
// Request, RAM read port and byte-stream signals of bram_frame_reader.
// The reader sits on the master side and the RAM/requester/sink on the slave side.
interface bram_frame_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic              abort;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, base, len, abort, ram_rdata, m_ready,
        output ram_addr, m_data, m_valid, m_last, busy, done, err
    );

    modport slave (
        output start, base, len, abort, ram_rdata, m_ready,
        input  ram_addr, m_data, m_valid, m_last, busy, done, err
    );
endinterface

// File: rtl/bram_frame_reader.sv
// Streams len bytes from a registered-output BRAM starting at base (address wraps at DEPTH)
// through a 4-entry FIFO with valid/ready backpressure, abort and start checking.
module bram_frame_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1501
) (
    input logic                 clk,
    input logic                 rstn,
    bram_frame_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam int                STAGES    = 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] frame_len;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              busy;
    logic              done;
    logic              err;

    // Read pipeline: [0] = address register stage, [STAGES] = RAM output stage.
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   last_pipe;

    logic [DATA_W-1:0] fifo_data [4];
    logic [3:0]        fifo_last;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;

    logic              start_ok;
    logic              issue;
    logic              final_rd;
    logic              push;
    logic              pop;
    logic              m_valid;
    logic [2:0]        inflight;

    assign inflight = {2'b00, vld_pipe[0]} + {2'b00, vld_pipe[STAGES]};
    assign start_ok = (bus.len != '0) && ({1'b0, bus.len} <= DEPTH_W) && (bus.base <= LAST_ADDR);
    assign final_rd = (issued == frame_len - 1'b1);

    // Reserve FIFO space for every outstanding read so no returning byte is ever dropped.
    assign issue = (state == STREAM) && !bus.abort && (issued != frame_len) &&
                   ((fifo_count + inflight) < 3'd4);
    assign push  = (state == STREAM) && !bus.abort && vld_pipe[STAGES];
    assign pop   = (state == STREAM) && m_valid && bus.m_ready;

    assign m_valid      = (fifo_count != 3'd0);
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = fifo_data[rd_ptr];
    assign bus.m_last   = m_valid && fifo_last[rd_ptr];
    assign bus.ram_addr = ram_addr;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            frame_len  <= '0;
            issued     <= '0;
            rd_addr    <= '0;
            ram_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            vld_pipe   <= '0;
            last_pipe  <= '0;
            fifo_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
            last_pipe <= {last_pipe[STAGES-1:0], issue && final_rd};

            if (issue) begin
                ram_addr <= rd_addr;
                rd_addr  <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                issued   <= issued + 1'b1;
            end

            if (push) begin
                fifo_data[wr_ptr] <= bus.ram_rdata;
                fifo_last[wr_ptr] <= last_pipe[STAGES];
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase

            // FSM updates come last so abort's FIFO clear overrides the datapath above.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            state     <= STREAM;
                            busy      <= 1'b1;
                            frame_len <= bus.len;
                            rd_addr   <= bus.base;
                            issued    <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (bus.abort) begin
                        state      <= FLUSH;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fifo_count <= '0;
                    end else if (pop && fifo_last[rd_ptr]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    // The RAM-stage read shifts out this edge without a push.
                    if (!vld_pipe[0]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bram_frame_reader.sv
// Randomized and directed bench for bram_frame_reader; expected bytes come from
// mem[(base+i) % DEPTH] and the cycle-level latency rules.
module tb_bram_frame_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1501;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bram_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_frame_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    int n_chk   = 0;
    int n_fail  = 0;
    int max_cnt = 0;

    // Registered-output RAM: data for the address seen at edge N is visible after edge N+1.
    always @(posedge clk) begin
        int a;
        a = int'(bus.ram_addr);
        bus.ram_rdata <= (a < DEPTH) ? mem[a] : '0;
    end

    always @(negedge clk) if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_val(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return {7'd0, bus.ram_addr, bus.m_data, bus.m_valid, bus.m_last,
                bus.busy, bus.done, bus.err};
    endfunction

    task automatic run_frame(input int b, input int l, input int mode, input bit inject,
                             input bit with_abort);
        logic [DATA_W-1:0] exp_q[$];
        int got_n = 0, first_v = -1, first_hs = -1, last_hs = -1, done_c = -1;
        bit busy_bad = 0, err_seen = 0, stall = 0, fin = 0;
        logic [DATA_W:0] prev = '0;
        for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
        max_cnt = 0;
        bus.base  = ADDR_W'(b);
        bus.len   = ADDR_W'(l);
        bus.start = 1'b1;
        bus.abort = with_abort;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 0; c < l * 8 + 40 && !fin; c++) begin
            bus.m_ready = ready_val(mode, c);
            if (inject && c == 5) begin
                bus.start = 1'b1;
                bus.base  = ADDR_W'((b + 7) % DEPTH);
                bus.len   = '0;
            end
            @(negedge clk);
            if (bus.err) err_seen = 1;
            if (mode == 0 && c >= 1 && c <= l) chk("ram_addr", bus.ram_addr, (b + c - 1) % DEPTH);
            if (stall) chk("stall_hold", {bus.m_last, bus.m_data}, prev);
            stall = bus.m_valid && !bus.m_ready;
            prev  = {bus.m_last, bus.m_data};
            if (bus.m_valid && first_v < 0) first_v = c;
            if (bus.m_valid && bus.m_ready) begin
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                if (got_n < l) chk("byte", {bus.m_last, bus.m_data}, {got_n == l - 1, exp_q[got_n]});
                else chk("byte_overrun", got_n, l - 1);
                got_n++;
            end
            if (bus.done) begin
                done_c = c;
                fin    = 1;
                chk("busy_at_done", bus.busy, 0);
            end else if (!bus.busy) begin
                busy_bad = 1;
            end
            tick();
            bus.start = 1'b0;
        end
        chk("done_seen", fin, 1);
        chk("byte_count", got_n, l);
        chk("first_valid_cyc", first_v, 3);
        chk("done_after_last", done_c, last_hs + 1);
        chk("busy_held", busy_bad, 0);
        chk("no_err_in_frame", err_seen, 0);
        chk("fifo_max_le4", max_cnt <= 4, 1);
        if (mode == 0) chk("no_bubbles", last_hs - first_hs, l - 1);
        @(negedge clk);
        chk("post_done_quiet", {bus.done, bus.m_valid, bus.busy}, 0);
        tick();
    endtask

    task automatic bad_start(input int b, input int l, input string tag);
        bus.base  = ADDR_W'(b);
        bus.len   = ADDR_W'(l);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, bus.err, 1);
        chk({tag, "_idle"}, {bus.busy, bus.m_valid}, 0);
        tick();
        @(negedge clk);
        chk({tag, "_err_once"}, {bus.err, bus.busy, bus.m_valid}, 0);
        tick();
    endtask

    task automatic abort_test(input int b);
        int hs = 0, busy_c = -1;
        bit done_seen = 0, valid_seen = 0;
        bus.base    = ADDR_W'(b);
        bus.len     = ADDR_W'(100);
        bus.m_ready = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 40 && hs < 5; c++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) begin
                chk("abort_pre_byte", bus.m_data, mem[(b + hs) % DEPTH]);
                hs++;
            end
            tick();
        end
        chk("abort_hs5", hs, 5);
        bus.abort   = 1'b1;
        bus.m_ready = 1'b0;
        tick();
        bus.abort   = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("abort_valid_off", bus.m_valid, 0);
            if (bus.m_valid) valid_seen = 1;
            if (bus.done) done_seen = 1;
            if (!bus.busy && busy_c < 0) busy_c = c;
            tick();
        end
        chk("abort_no_valid", valid_seen, 0);
        chk("abort_no_done", done_seen, 0);
        chk("abort_busy_drop", busy_c >= 0 && busy_c <= 3, 1);
        run_frame((b + 300) % DEPTH, 2, 0, 0, 0);
    endtask

    task automatic reset_test();
        bus.base    = '0;
        bus.len     = ADDR_W'(50);
        bus.m_ready = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        #2 rstn = 1'b0;
        #1 chk("rst_async_outs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_held_outs", all_outs(), 0);
        rstn = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_no_done", {bus.done, bus.busy, bus.m_valid}, 0);
        tick();
        run_frame(100, 3, 0, 0, 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.base    = '0;
        bus.len     = '0;
        bus.abort   = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        repeat (2) @(posedge clk);
        #1 chk("reset_state", all_outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        run_frame(0, 64, 0, 0, 0);
        run_frame(1498, 5, 0, 0, 0);
        run_frame(37, 16, 1, 0, 0);
        bad_start(0, 0, "len0");
        bad_start(0, 1502, "len1502");
        bad_start(1501, 1, "base1501");
        run_frame(200, 1, 0, 0, 0);
        run_frame(0, DEPTH, 0, 0, 0);

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ignored", {bus.busy, bus.err, bus.m_valid, bus.done}, 0);
        tick();

        run_frame(1400, 20, 2, 1, 1);
        abort_test(10);
        reset_test();

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        for (int k = 0; k < 10; k++) begin
            int b, l, m;
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            m = $urandom_range(0, 2);
            run_frame(b, l, m, l >= 8, 1'($urandom_range(0, 1)));
        end
        run_frame(DEPTH - 1, 3, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
